// File: rtl/audio_seq_pkg.sv
// Shared types and constant tables for the tone sequencer.
// Holds the FSM state enum, ROM note format, half-period table and the song.
package audio_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PLAY,
    GAP
  } state_t;

  typedef struct packed {
    logic [1:0] dur;
    logic [2:0] pitch;
  } note_t;

  // Index 0 is the rest slot and is never used as a half-period.
  localparam logic [17:0] HALF_PERIOD [8] = '{
    18'd0,
    18'd191131,
    18'd170242,
    18'd151515,
    18'd131926,
    18'd127551,
    18'd113636,
    18'd101235
  };

  // Each entry is {dur[1:0], pitch[2:0]}.
  localparam note_t SONG_ROM [16] = '{
    5'b00_001,
    5'b00_010,
    5'b01_011,
    5'b00_000,
    5'b00_100,
    5'b00_101,
    5'b01_110,
    5'b00_111,
    5'b00_111,
    5'b00_110,
    5'b01_101,
    5'b00_000,
    5'b00_100,
    5'b00_011,
    5'b10_010,
    5'b00_001
  };

endpackage

// File: rtl/square_tone_gen.sv
// Square-wave phase generator: snd toggles every hp+1 enabled cycles.
// Ports: clk, reset (sync, high), enable, load (clears phase), hp[17:0] -> snd.
module square_tone_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [17:0] hp,
  output logic        snd
);

  logic [17:0] phase_cnt;

  always_ff @(posedge clk) begin
    if (reset || load) begin
      phase_cnt <= '0;
      snd       <= 1'b0;
    end else if (enable) begin
      if (phase_cnt == hp) begin
        phase_cnt <= '0;
        snd       <= ~snd;
      end else begin
        phase_cnt <= phase_cnt + 18'd1;
      end
    end
  end

endmodule

// File: rtl/tone_sequencer.sv
// Plays SONG_ROM as a square tone mixed onto the mic samples sent to the DAC.
// Ports: CLOCK_50, reset, start/stop/loop control, audio handshake, busy/note_idx/done.
import audio_seq_pkg::*;

module tone_sequencer #(
  parameter int          SONG_LEN   = 16,
  parameter logic [31:0] AMPL       = 32'd10000000,
  parameter int          DUR_UNIT   = 6_250_000,
  parameter int          GAP_CYCLES = 2_500_000,
  parameter int          HP_SHIFT   = 0
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        loop,
  input  logic        audio_in_available,
  input  logic        audio_out_allowed,
  input  logic [31:0] left_channel_audio_in,
  input  logic [31:0] right_channel_audio_in,
  output logic        read_audio_in,
  output logic        write_audio_out,
  output logic [31:0] left_channel_audio_out,
  output logic [31:0] right_channel_audio_out,
  output logic        busy,
  output logic [3:0]  note_idx,
  output logic        done
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [2:0]  pitch_q, pitch_d;
  logic [17:0] hp_q, hp_d;
  logic [28:0] dur_q, dur_d;
  logic [GW-1:0] gap_q, gap_d;
  logic        done_q, done_d;

  note_t       rom_note;
  logic        last;
  logic        snd;
  logic        hs;
  logic [31:0] tone;

  assign rom_note = SONG_ROM[idx_q];
  assign last     = (idx_q == 4'(SONG_LEN - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pitch_q <= '0;
      hp_q    <= '0;
      dur_q   <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pitch_q <= pitch_d;
      hp_q    <= hp_d;
      dur_q   <= dur_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pitch_d = pitch_q;
    hp_d    = hp_q;
    dur_d   = dur_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        pitch_d = rom_note.pitch;
        hp_d    = HALF_PERIOD[rom_note.pitch] >> HP_SHIFT;
        dur_d   = (29'(DUR_UNIT) << rom_note.dur) - 29'd1;
        state_d = PLAY;
      end
      PLAY: begin
        dur_d = dur_q - 29'd1;
        if (dur_q == '0) begin
          state_d = GAP;
          gap_d   = GW'(GAP_CYCLES - 1);
        end
      end
      GAP: begin
        gap_d = gap_q - GW'(1);
        if (gap_q == '0) begin
          if (!last) begin
            idx_d   = idx_q + 4'd1;
            state_d = LOAD;
          end else if (loop) begin
            idx_d   = '0;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything, including a completion in the same cycle.
    if (stop && state_q != IDLE) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
  end

  square_tone_gen u_gen (
    .clk    (CLOCK_50),
    .reset  (reset),
    .enable (state_q == PLAY && pitch_q != 3'd0),
    .load   (state_q == LOAD),
    .hp     (hp_q),
    .snd    (snd)
  );

  always_comb begin
    tone = '0;
    if (state_q == PLAY && pitch_q != 3'd0)
      tone = snd ? AMPL : (32'd0 - AMPL);
  end

  assign hs                      = audio_in_available & audio_out_allowed;
  assign read_audio_in           = hs;
  assign write_audio_out         = hs;
  assign left_channel_audio_out  = left_channel_audio_in + tone;
  assign right_channel_audio_out = right_channel_audio_in + tone;

  assign busy     = (state_q != IDLE);
  assign note_idx = idx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with shortened timing parameters.
// Cycle indices below count from the first LOAD cycle of a pass.
module tb_tone_sequencer;

  localparam logic [31:0] AMPL = 32'd10000000;

  logic        CLOCK_50 = 1'b0;
  logic        reset, start, stop, loop;
  logic        avail, allowed;
  logic [31:0] lin, rin, lout, rout;
  logic        rd, wr, busy, done;
  logic [3:0]  note_idx;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50)
    if (done === 1'b1) done_cnt++;

  tone_sequencer #(
    .DUR_UNIT   (8),
    .GAP_CYCLES (4),
    .HP_SHIFT   (16)
  ) dut (
    .CLOCK_50                (CLOCK_50),
    .reset                   (reset),
    .start                   (start),
    .stop                    (stop),
    .loop                    (loop),
    .audio_in_available      (avail),
    .audio_out_allowed       (allowed),
    .left_channel_audio_in   (lin),
    .right_channel_audio_in  (rin),
    .read_audio_in           (rd),
    .write_audio_out         (wr),
    .left_channel_audio_out  (lout),
    .right_channel_audio_out (rout),
    .busy                    (busy),
    .note_idx                (note_idx),
    .done                    (done)
  );

  task automatic step(input int n = 1);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1; start = 1; stop = 0; loop = 0;
    avail = 1; allowed = 1; lin = 32'd1000; rin = 32'd5;

    // Reset held with start asserted
    step(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_idx", 32'(note_idx), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_lout", lout, 32'd1000);
    chk("rst_rout", rout, 32'd5);
    reset = 0; start = 0;
    step(2);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done_cnt", done_cnt, 0);

    // First note: LOAD, 8 PLAY cycles, 4 GAP cycles
    start = 1;
    step();
    start = 0;
    chk("load_busy", 32'(busy), 1);
    chk("load_idx", 32'(note_idx), 0);
    chk("load_tone0", lout, 32'd1000);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("play_l", lout,
          (i >= 3 && i < 6) ? 32'd1000 + AMPL : 32'd1000 - AMPL);
      if (i == 0) chk("play_r", rout, 32'd5 - AMPL);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk("gap_l", lout, 32'd1000);
      chk("gap_idx", 32'(note_idx), 0);
    end
    step();
    chk("n1_idx", 32'(note_idx), 1);
    chk("n1_busy", 32'(busy), 1);

    // Rest of the pass; pass is 256 busy cycles, done at index 256
    for (int k = 14; k <= 256; k++) begin
      step();
      if (k == 50) begin
        chk("rest_idx", 32'(note_idx), 3);
        chk("rest_tone0", lout, 32'd1000);
      end
      if (k == 255) begin
        chk("last_idx", 32'(note_idx), 15);
        chk("last_busy", 32'(busy), 1);
        chk("last_nodone", 32'(done), 0);
      end
    end
    chk("done_hi", 32'(done), 1);
    chk("done_busy", 32'(busy), 0);
    chk("done_idx", 32'(note_idx), 15);
    step();
    chk("done_lo", 32'(done), 0);
    chk("done_once", done_cnt, 1);

    // Looping pass
    loop = 1; start = 1;
    step();
    start = 0;
    for (int k = 1; k <= 257; k++) begin
      step();
      if (k == 255) chk("loop_last_idx", 32'(note_idx), 15);
      if (k == 256) begin
        chk("loop_busy", 32'(busy), 1);
        chk("loop_wrap_idx", 32'(note_idx), 0);
        chk("loop_load_tone0", lout, 32'd1000);
      end
      if (k == 257) chk("loop_play", lout, 32'd1000 - AMPL);
    end
    chk("loop_nodone", done_cnt, 1);

    // Stop mid-PLAY
    stop = 1;
    step();
    stop = 0; loop = 0;
    chk("stop_busy", 32'(busy), 0);
    chk("stop_tone0", lout, 32'd1000);
    chk("stop_done", 32'(done), 0);
    step(2);
    chk("stop_nodone", done_cnt, 1);

    // start and stop together from IDLE
    start = 1; stop = 1;
    step();
    start = 0; stop = 0;
    chk("ss_idle", 32'(busy), 0);

    // start while busy is ignored
    start = 1;
    step();
    start = 0;
    step(13);
    chk("sb_idx1", 32'(note_idx), 1);
    start = 1;
    step();
    start = 0;
    step();
    chk("sb_busy", 32'(busy), 1);
    chk("sb_idx", 32'(note_idx), 1);
    stop = 1;
    step();
    stop = 0;
    chk("sb_stop", 32'(busy), 0);

    // Handshake and wrap arithmetic
    allowed = 0;
    #1;
    chk("hs_rd0", 32'(rd), 0);
    chk("hs_wr0", 32'(wr), 0);
    chk("hs_track", lout, 32'd1000);
    allowed = 1;
    #1;
    chk("hs_rd1", 32'(rd), 1);
    chk("hs_wr1", 32'(wr), 1);
    lin = 32'hFFFF_FFFF;
    #1;
    chk("wrap_idle", lout, 32'hFFFF_FFFF);
    start = 1;
    step();
    start = 0;
    step();
    chk("wrap_neg", lout, 32'hFF67_697F);
    step(3);
    chk("wrap_pos", lout, 32'd9999999);
    allowed = 0;
    #1;
    chk("wrap_wr0", 32'(wr), 0);
    chk("wrap_track", lout, 32'd9999999);
    allowed = 1;

    // Reset mid-note
    reset = 1;
    step();
    reset = 0;
    chk("mr_busy", 32'(busy), 0);
    chk("mr_idx", 32'(note_idx), 0);
    chk("mr_done", 32'(done), 0);
    chk("mr_tone0", lout, 32'hFFFF_FFFF);
    step(2);
    chk("mr_nodone", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
